// File: rtl/dense_layer_seq_if.sv
// Bus bundle for dense_layer_seq: start/done handshake, operand arrays,
// weight-memory read port and neuron results.
interface dense_layer_seq_if #(
    parameter int NUM_NEURONS = 32,
    parameter int INPUT_DIM   = 196,
    parameter int WIDTH       = 8,
    parameter int PAR         = 4,
    parameter int ADDR_W      = $clog2(((NUM_NEURONS + PAR - 1) / PAR) * INPUT_DIM)
);
    logic                      start;
    logic signed [2*WIDTH-1:0] date_intrare [INPUT_DIM];
    logic signed [WIDTH-1:0]   biases       [NUM_NEURONS];
    logic [ADDR_W-1:0]         weight_addr;
    logic [PAR*WIDTH-1:0]      weight_rdata;
    logic signed [4*WIDTH-1:0] date_iesire  [NUM_NEURONS];
    logic                      busy;
    logic                      layer_terminat;

    modport master (
        output start, date_intrare, biases, weight_rdata,
        input  weight_addr, date_iesire, busy, layer_terminat
    );

    modport slave (
        input  start, date_intrare, biases, weight_rdata,
        output weight_addr, date_iesire, busy, layer_terminat
    );
endinterface

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: PAR MAC lanes sweep the neurons group by group,
// weights streamed from an external synchronous memory. Optional ReLU on write: DENSE_RELU_EN.
module dense_layer_seq #(
    parameter int NUM_NEURONS = 32,
    parameter int INPUT_DIM   = 196,
    parameter int WIDTH       = 8,
    parameter int PAR         = 4,
    parameter int ADDR_W      = $clog2(((NUM_NEURONS + PAR - 1) / PAR) * INPUT_DIM)
) (
    input logic              clock,
    input logic              reset,
    dense_layer_seq_if.slave bus
);
    localparam int NGRP  = (NUM_NEURONS + PAR - 1) / PAR;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int IDX_W = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
    localparam int AW    = 4 * WIDTH;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    r_state;
    logic [GRP_W-1:0]          r_grp;
    logic [IDX_W-1:0]          r_idx;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_busy;
    logic                      r_done;
    logic signed [2*WIDTH-1:0] r_x   [INPUT_DIM];
    logic signed [AW-1:0]      r_acc [PAR];
    logic signed [AW-1:0]      r_out [NUM_NEURONS];

    logic signed [2*WIDTH-1:0] w_x_cur;
    logic signed [WIDTH-1:0]   w_lane [PAR];
    logic signed [3*WIDTH-1:0] w_p3   [PAR];
    logic signed [AW-1:0]      w_prod [PAR];

    function automatic logic signed [AW-1:0] activate(input logic signed [AW-1:0] a);
`ifdef DENSE_RELU_EN
        if (a[AW-1]) begin
            return '0;
        end else begin
            return a;
        end
`else
        return a;
`endif
    endfunction

    assign bus.weight_addr    = r_addr;
    assign bus.busy           = r_busy;
    assign bus.layer_terminat = r_done;
    assign bus.date_iesire    = r_out;

    // Per-lane product of the current input with its streamed weight, sign-extended to AW.
    always_comb begin
        w_x_cur = r_x[r_idx];
        for (int k = 0; k < PAR; k++) begin
            w_lane[k] = bus.weight_rdata[k*WIDTH +: WIDTH];
            w_p3[k]   = $signed({{WIDTH{w_x_cur[2*WIDTH-1]}}, w_x_cur})
                      * $signed({{(2*WIDTH){w_lane[k][WIDTH-1]}}, w_lane[k]});
            w_prod[k] = {{WIDTH{w_p3[k][3*WIDTH-1]}}, w_p3[k]};
        end
    end

    // Layer sequencer; the address runs one step ahead of r_idx to hide the memory latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grp   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < INPUT_DIM; i++) r_x[i] <= '0;
            for (int k = 0; k < PAR; k++) r_acc[k] <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) r_out[n] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_x     <= bus.date_intrare;
                        r_grp   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    // Lanes past the last neuron start from zero and are never written back.
                    for (int k = 0; k < PAR; k++) r_acc[k] <= '0;
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        if (GRP_W'(n / PAR) == r_grp) begin
                            r_acc[n % PAR] <= {{(AW-WIDTH){bus.biases[n][WIDTH-1]}}, bus.biases[n]};
                        end
                    end
                    r_idx <= '0;
                    if (INPUT_DIM > 1) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    for (int k = 0; k < PAR; k++) r_acc[k] <= r_acc[k] + w_prod[k];
                    if (int'(r_idx) < INPUT_DIM - 2) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        if (GRP_W'(n / PAR) == r_grp) begin
                            r_out[n] <= activate(r_acc[n % PAR]);
                        end
                    end
                    if (r_grp == LAST_GRP) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_grp   <= r_grp + GRP_W'(1);
                        r_addr  <= ADDR_W'((int'(r_grp) + 1) * INPUT_DIM);
                        r_state <= S_INIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench for dense_layer_seq: five neurons, two lanes (partial last group),
// 196-element input, weights served from a synchronous memory model.
module tb_dense_layer_seq;
    localparam int N   = 5;
    localparam int D   = 196;
    localparam int W   = 8;
    localparam int P   = 2;
    localparam int G   = (N + P - 1) / P;
    localparam int AWD = $clog2(G * D);
    // Edges from start acceptance to the first layer_terminat sample (cycle G*(D+2)+1).
    localparam int LAT = G * (D + 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dense_layer_seq_if #(.NUM_NEURONS(N), .INPUT_DIM(D), .WIDTH(W), .PAR(P), .ADDR_W(AWD)) bus ();

    dense_layer_seq #(.NUM_NEURONS(N), .INPUT_DIM(D), .WIDTH(W), .PAR(P), .ADDR_W(AWD)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    logic [P*W-1:0]  wmem [G*D];
    int              xv [D];
    int              wv [N][D];
    int              bv [N];
    logic [N*32-1:0] exp_q [$];
    int              acc_q [$];
    int              checks   = 0;
    int              errors   = 0;
    int              cyc      = 0;
    int              busy_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.weight_rdata <= wmem[bus.weight_addr];
    end

    // Reference: y[n] = act(bias[n] + sum_i x[i]*w[n][i]), kept to 32 bits.
    function automatic logic [N*32-1:0] model();
        logic [N*32-1:0]    r;
        longint             s;
        logic signed [31:0] y;
        r = '0;
        for (int n = 0; n < N; n++) begin
            s = longint'(bv[n]);
            for (int i = 0; i < D; i++) s += longint'(xv[i]) * longint'(wv[n][i]);
            y = s[31:0];
`ifdef DENSE_RELU_EN
            if (y < 0) y = 0;
`endif
            r[n*32 +: 32] = y;
        end
        return r;
    endfunction

    task automatic load();
        logic [P*W-1:0] word;
        for (int g = 0; g < G; g++) begin
            for (int i = 0; i < D; i++) begin
                for (int k = 0; k < P; k++) begin
                    if (g * P + k < N) word[k*W +: W] = W'(wv[g*P+k][i]);
                    else               word[k*W +: W] = W'($urandom);
                end
                wmem[g*D+i] = word;
            end
        end
        for (int n = 0; n < N; n++) bus.biases[n] = W'(bv[n]);
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic start_run(input bit push, input bit disturb);
        @(negedge clk);
        for (int i = 0; i < D; i++) bus.date_intrare[i] = (2*W)'(xv[i]);
        bus.start = 1'b1;
        if (push) begin
            exp_q.push_back(model());
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (disturb) begin
            repeat (40) @(negedge clk);
            bus.start = 1'b1;
            for (int i = 0; i < D; i++) bus.date_intrare[i] = (2*W)'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
            repeat (300) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < LAT + 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.layer_terminat) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no layer_terminat, expected one within %0d cycles", LAT + 10);
        end
    endtask

    task automatic run(input bit disturb);
        start_run(1'b1, disturb);
        wait_done();
    endtask

    task automatic randomize_all();
        for (int i = 0; i < D; i++) xv[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int n = 0; n < N; n++) begin
            bv[n] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < D; i++) wv[n][i] = int'($urandom_range(0, 255)) - 128;
        end
        load();
    endtask

    // Monitor: pops the expected result set whenever the DUT signals completion.
    always @(negedge clk) begin
        logic [N*32-1:0] e;
        int              a;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.layer_terminat) begin
                checks++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got layer_terminat at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    for (int n = 0; n < N; n++) begin
                        checks++;
                        if (bus.date_iesire[n] !== $signed(e[n*32 +: 32])) begin
                            errors++;
                            $display("FAIL out[%0d]: got %0d expected %0d", n,
                                     bus.date_iesire[n], $signed(e[n*32 +: 32]));
                        end
                    end
                    checks++;
                    if (cyc - a != LAT) begin
                        errors++;
                        $display("FAIL done_latency: got %0d expected %0d", cyc - a, LAT);
                    end
                    checks++;
                    if (busy_cnt != LAT) begin
                        errors++;
                        $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, LAT);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < D; i++) bus.date_intrare[i] = '0;
        for (int n = 0; n < N; n++) bus.biases[n] = '0;
        for (int a = 0; a < G * D; a++) wmem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.layer_terminat), 0);
        chk("rst_addr", longint'(bus.weight_addr), 0);
        for (int n = 0; n < N; n++) chk("rst_out", longint'(bus.date_iesire[n]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp inputs, unit weights, distinct biases.
        for (int i = 0; i < D; i++) xv[i] = i % 3 + 1;
        for (int n = 0; n < N; n++) begin
            bv[n] = n;
            for (int i = 0; i < D; i++) wv[n][i] = 1;
        end
        load();
        run(1'b0);

        // Uniform weights, zero biases across the partial last group.
        for (int i = 0; i < D; i++) xv[i] = 1;
        for (int n = 0; n < N; n++) begin
            bv[n] = 0;
            for (int i = 0; i < D; i++) wv[n][i] = 2;
        end
        load();
        run(1'b0);

        // Extreme negative operands, then a large negative sum.
        for (int i = 0; i < D; i++) xv[i] = -100;
        for (int n = 0; n < N; n++) begin
            bv[n] = -1;
            for (int i = 0; i < D; i++) wv[n][i] = -128;
        end
        load();
        run(1'b0);
        for (int n = 0; n < N; n++) for (int i = 0; i < D; i++) wv[n][i] = 127;
        load();
        run(1'b0);

        // Random back-to-back runs, the last one disturbed mid-flight.
        randomize_all();
        run(1'b0);
        randomize_all();
        run(1'b0);
        randomize_all();
        run(1'b1);

        // Abort a run with reset, then start fresh.
        randomize_all();
        start_run(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_done", longint'(bus.layer_terminat), 0);
        chk("abort_addr", longint'(bus.weight_addr), 0);
        for (int n = 0; n < N; n++) chk("abort_out", longint'(bus.date_iesire[n]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        randomize_all();
        run(1'b0);
        randomize_all();
        run(1'b0);

        repeat (5) @(negedge clk);
        chk("pending_results", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
Time-multiplexed, parametrised fully-connected layer. PAR MAC lanes process NUM_NEURONS neurons in groups of PAR. Weights stream from an external synchronous weight ROM/RAM instead of arriving as a full array port, which cuts area for large layers. It sits between layers of the MLP pipeline and uses a start/done handshake so layers can be chained.

Parameters:
NUM_NEURONS, 32, number of output neurons
INPUT_DIM, 196, input vector length
WIDTH, 8, weight/bias width; input width 2*WIDTH, output width 4*WIDTH
PAR, 4, parallel MAC lanes (1..NUM_NEURONS; need not divide NUM_NEURONS)
ADDR_W, $clog2(ceil(NUM_NEURONS/PAR)*INPUT_DIM), weight address width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; accepted only in IDLE
date_intrare  in  signed [2*WIDTH-1:0] x INPUT_DIM  input vector, sampled on the accepted start cycle
biases  in  signed [WIDTH-1:0] x NUM_NEURONS  per-neuron bias, static during operation
weight_addr  out  ADDR_W  weight memory read address
weight_rdata  in  PAR*WIDTH  PAR signed weights; lane k at bits [k*WIDTH +: WIDTH]; valid 1 cycle after weight_addr
date_iesire  out  signed [4*WIDTH-1:0] x NUM_NEURONS  neuron results
busy  out  1  high from the cycle after start is accepted until done
layer_terminat  out  1  one-cycle pulse when all results are valid

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, layer_terminat=0, weight_addr=0, all date_iesire=0, input register cleared.
- G = ceil(NUM_NEURONS/PAR) groups; group g covers neurons g*PAR .. g*PAR+PAR-1. Lanes whose neuron index is >= NUM_NEURONS are computed but never written.
- Weight layout: address g*INPUT_DIM+i holds the weights of input i for every lane of group g.
- FSM:
  - IDLE: on start=1, latch date_intrare, set g=0 -> INIT.
  - INIT (1 cycle): accumulator[k] = sign-extend(bias of neuron g*PAR+k) to 4*WIDTH; weight_addr = g*INPUT_DIM; i=0 -> MAC.
  - MAC (INPUT_DIM cycles): each cycle accumulator[k] += input[i] * weight_rdata lane k, where i is the index addressed in the previous cycle. Advance weight_addr while i < INPUT_DIM-1. After the last product -> WRITE.
  - WRITE (1 cycle): copy accumulators to date_iesire[g*PAR+k] (activation applied, see Optional Feature). If g == G-1 -> DONE, else g++ -> INIT.
  - DONE (1 cycle): layer_terminat=1, busy=0 -> IDLE.
- Latency: start accepted at cycle 0; layer_terminat high at cycle G*(INPUT_DIM+2)+1.
- Arithmetic: product is 3*WIDTH signed, sign-extended to 4*WIDTH. Accumulation wraps in two's complement with no saturation.
- start while busy: ignored; no restart, no error.
- date_iesire holds its values after done until the next WRITE or reset. Entries from unwritten groups keep their previous values during a run.
- Changes to date_intrare after the start cycle have no effect. biases must stay stable while busy.
- Reset mid-operation: immediate return to IDLE with all outputs zero; any partial results are discarded.
- INPUT_DIM=1: MAC lasts 1 cycle and the rules above still hold.

Optional Feature:
Macro DENSE_RELU_EN. When defined, WRITE stores max(acc, 0): negative accumulators become 0. When undefined, WRITE stores the raw accumulator. No timing difference either way.

Test Plan:
- WIDTH=8, NUM_NEURONS=4, INPUT_DIM=3, PAR=2; inputs {1,2,3}, all weights 1, biases {0,1,2,3} -> outputs {6,7,8,9}; layer_terminat pulses exactly at cycle 2*5+1=11 after start; busy high cycles 1..10.
- NUM_NEURONS=5, PAR=2 (partial last group); weights 2, inputs {1,1,1}, biases 0 -> all five outputs 6; three groups, done at cycle 16.
- Negative case: input -100, weight -128 across INPUT_DIM=196, bias -1 -> output 2508799. Then weight +127 -> raw -2489201, or 0 with DENSE_RELU_EN defined.
- Second start pulse during busy and mid-run changes to date_intrare -> results and done timing identical to an undisturbed run.
- Assert reset low at cycle 5 of a run -> outputs 0, busy 0 asynchronously. A fresh start after release -> correct results, no leftover accumulator state.
- Two back-to-back runs with different inputs, second start the cycle after done -> second result set correct, one layer_terminat pulse per run.
